// File: rtl/mem_wr_pkg.sv
`default_nettype none
// ============================================================================
// Package   : mem_wr_pkg
// Purpose   : Shared types and constants for the word-memory writer slice.
//             BYTES_PER_WORD - bytes packed into one memory word
//             byte_t         - one byte lane
//             wr_state_t     - writer FSM states
// Revision  : 1.0 - initial release
// ============================================================================
package mem_wr_pkg;

   localparam int BYTES_PER_WORD = 4;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } wr_state_t;

endpackage : mem_wr_pkg
`default_nettype wire

// File: rtl/mem_word_writer_byte_lane_packer.sv
`default_nettype none
// ============================================================================
// Module    : byte_lane_packer
// Purpose   : Holds the four byte lanes of the word being assembled.
// Ports     : clk      in   clock
//             rst_n    in   asynchronous active-low reset (clears all lanes)
//             clr_i    in   synchronous clear of all lanes
//             load_i   in   write din_i into lane lane_i
//             lane_i   in   destination lane index (0 = MSB byte of the word)
//             din_i    in   byte to store
//             lanes_o  out  current lane contents [0:3]
// Revision  : 1.0 - initial release
// ============================================================================
module byte_lane_packer
   import mem_wr_pkg::*;
#(
   parameter int BYTE_W = 8
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                clr_i,
   input  logic                                load_i,
   input  logic [$clog2(BYTES_PER_WORD)-1:0]   lane_i,
   input  logic [BYTE_W-1:0]                   din_i,
   output logic [BYTE_W-1:0]                   lanes_o [0:BYTES_PER_WORD-1]
);

   localparam int LANE_W = $clog2(BYTES_PER_WORD);

   logic [BYTE_W-1:0] lanes_q [0:BYTES_PER_WORD-1];

   generate
      for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               lanes_q[gi] <= '0;
            end else if (clr_i) begin
               lanes_q[gi] <= '0;
            end else if (load_i && (lane_i == LANE_W'(gi))) begin
               lanes_q[gi] <= din_i;
            end
         end
         assign lanes_o[gi] = lanes_q[gi];
      end
   endgenerate

endmodule : byte_lane_packer
`default_nettype wire

// File: rtl/mem_word_writer.sv
`default_nettype none
// ============================================================================
// Module    : mem_word_writer
// Purpose   : Packs a valid/ready byte stream into 32-bit words and writes
//             WORD_COUNT words to consecutive word addresses from a latched
//             base address; done then drives the memory's dump input.
// Ports     : clk, rst_n        clock, asynchronous active-low reset
//             start_i           job request (accepted only in IDLE or DONE)
//             base_addr_i       job base byte address (low 2 bits dropped)
//             in_valid_i/in_data_i/in_ready_o   byte stream handshake
//             wr_en_o           one-cycle write strobe per word
//             addr_o            memory byte address of the current write
//             data_out_o[0:3]   word lanes, [0] = most significant byte
//             init_addr_o       latched word-aligned base address
//             busy_o, done_o    job in progress / job complete
//             stall_cnt_o       (only with WR_STALL_CNT_EN) idle FILL cycles
// Config    : `define WR_STALL_CNT_EN adds the stall_cnt_o port and counter.
// Revision  : 1.0 - initial release
// ============================================================================
module mem_word_writer
   import mem_wr_pkg::*;
#(
   parameter int WORD_COUNT = 43,
   parameter int ADDR_W     = 9,
   parameter int BYTE_W     = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic [ADDR_W-1:0]   base_addr_i,
   input  logic                in_valid_i,
   input  logic [BYTE_W-1:0]   in_data_i,
   output logic                in_ready_o,
   output logic                wr_en_o,
   output logic [ADDR_W-1:0]   addr_o,
   output logic [BYTE_W-1:0]   data_out_o [0:BYTES_PER_WORD-1],
   output logic [ADDR_W-1:0]   init_addr_o,
   output logic                busy_o,
`ifdef WR_STALL_CNT_EN
   output logic                done_o,
   output logic [15:0]         stall_cnt_o
`else
   output logic                done_o
`endif
);

   localparam int LANE_W = $clog2(BYTES_PER_WORD);
   localparam int CNT_W  = $clog2(WORD_COUNT + 1);

   wr_state_t            state_q,     state_d;
   logic [LANE_W-1:0]    lane_q,      lane_d;
   logic [CNT_W-1:0]     word_cnt_q,  word_cnt_d;
   logic [ADDR_W-1:0]    addr_q,      addr_d;
   logic [ADDR_W-1:0]    init_addr_q, init_addr_d;

   logic w_accept;
   logic w_start_ok;

   assign w_accept   = (state_q == FILL) && in_valid_i;
   assign w_start_ok = start_i && ((state_q == IDLE) || (state_q == DONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         lane_q      <= '0;
         word_cnt_q  <= '0;
         addr_q      <= '0;
         init_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         lane_q      <= lane_d;
         word_cnt_q  <= word_cnt_d;
         addr_q      <= addr_d;
         init_addr_q <= init_addr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      lane_d      = lane_q;
      word_cnt_d  = word_cnt_q;
      addr_d      = addr_q;
      init_addr_d = init_addr_q;
      case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               state_d     = FILL;
               init_addr_d = base_addr_i & ~ADDR_W'(3);
               word_cnt_d  = '0;
               lane_d      = '0;
            end
         end
         FILL: begin
            if (in_valid_i) begin
               lane_d = lane_q + LANE_W'(1);
               if (lane_q == LANE_W'(BYTES_PER_WORD - 1)) begin
                  state_d = WRITE;
                  // Address is computed on WRITE entry so it is a clean
                  // register output for the whole write cycle; the add
                  // wraps naturally at the top of the address space.
                  addr_d  = init_addr_q + (ADDR_W'(word_cnt_q) << 2);
               end
            end
         end
         WRITE: begin
            lane_d     = '0;
            word_cnt_d = word_cnt_q + CNT_W'(1);
            state_d    = (word_cnt_q == CNT_W'(WORD_COUNT - 1)) ? DONE : FILL;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Lanes are cleared on a new job so stale bytes never reach memory.
   byte_lane_packer #(
      .BYTE_W (BYTE_W)
   ) u_packer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (w_start_ok),
      .load_i  (w_accept),
      .lane_i  (lane_q),
      .din_i   (in_data_i),
      .lanes_o (data_out_o)
   );

   assign in_ready_o  = (state_q == FILL);
   assign wr_en_o     = (state_q == WRITE);
   assign busy_o      = (state_q == FILL) || (state_q == WRITE);
   assign done_o      = (state_q == DONE);
   assign addr_o      = addr_q;
   assign init_addr_o = init_addr_q;

`ifdef WR_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (w_start_ok) begin
         stall_cnt_q <= '0;
      end else if ((state_q == FILL) && !in_valid_i && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule : mem_word_writer
`default_nettype wire
